lsu_stage: RTL and testbench
============================

LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; SB_DEPTH, default 4, store-buffer entries, power of two and at least 2; SPM_BASE, default 0, SPM base address; SPM_AW, default 14, log2 of the SPM size in bytes; EXP_MISALIGN, default 3'd4, misalign exception code.
REQ-002 Clocking SHALL be: clk in 1, the only clock; reset in 1, synchronous, active-high.
REQ-003 Pipeline control SHALL be: stall in 1, hold MEM/WB; flush in 1, squash MEM/WB; busy out 1, request pipeline stall.
REQ-004 SPM port SHALL be: spm_rd_data in 32; spm_addr out ADDR_W; spm_as_ out 1, active-low strobe; spm_rw out 1, 1=read; spm_wr_data out 32; spm_be out 4, byte enables.
REQ-005 Bus inputs SHALL be: bus_rd_data in 32; bus_rdy_ in 1, active-low; bus_grnt_ in 1, active-low.
REQ-006 Bus outputs SHALL be: bus_req_ out 1; bus_addr out ADDR_W; bus_as_ out 1; bus_rw out 1, 1=read; bus_wr_data out 32; bus_be out 4.
REQ-007 EX/MEM inputs SHALL be: ex_en 1; ex_mem_op 4; ex_mem_wr_data 32; ex_out 32, address or ALU result; ex_pc 32; ex_br_flag 1; ex_ctrl_op 2; ex_dst_addr 5; ex_gpr_we_ 1; ex_exp_code 3.
REQ-008 Outputs SHALL be: fwd_data out 32; mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out, all registered and matching the widths of their ex_ counterparts.

Function
REQ-009 ex_mem_op SHALL encode: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 SHALL be treated as NOP.
REQ-010 An access SHALL be misaligned when it is a halfword access with addr[0]=1 or a word access with addr[1:0]!=0.
REQ-011 A misaligned access SHALL not strobe the SPM or the bus and SHALL not enqueue; the captured values SHALL be mem_exp_code=EXP_MISALIGN, mem_gpr_we_=1 and mem_out=ex_out.
REQ-012 The SPM region SHALL be addr[ADDR_W-1:SPM_AW]==SPM_BASE[ADDR_W-1:SPM_AW]; every other address SHALL be bus.
REQ-013 SPM access SHALL be combinational in the same cycle: spm_as_=0 when ex_en, the op is a memory op and the access is aligned; there SHALL be no stall.
REQ-014 Store data SHALL be byte/halfword replicated across lanes; be SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for halfword and 1111 for word.
REQ-015 Load data SHALL be the lane selected by addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend.
REQ-016 fwd_data SHALL be the current-cycle result: load data, or ex_out for non-loads.
REQ-017 Bus stores SHALL be posted into the store-buffer FIFO of {addr, data, be}, and SHALL enqueue exactly once, in the cycle with stall=0 and flush=0.
REQ-018 busy SHALL be 1 while a bus store is presented and the FIFO is full; the enqueue SHALL occur in the first non-stalled cycle after an entry frees.
REQ-019 A bus load SHALL wait until the FIFO is empty, then run one bus transaction.
REQ-020 For a bus load, busy SHALL be 1 from presentation until data is captured into an internal hold register; busy SHALL drop the cycle after bus_rdy_=0.
REQ-021 The hold register SHALL be released when the MEM/WB register advances.
REQ-022 The bus FSM SHALL have states IDLE, REQ, ACCESS and WAIT.
REQ-023 IDLE SHALL go to REQ when the FIFO is non-empty or a load is pending, with FIFO drain taking priority.
REQ-024 In REQ, bus_req_ SHALL be 0, and the FSM SHALL move to ACCESS when bus_grnt_=0.
REQ-025 ACCESS SHALL be one cycle with bus_as_=0 and addr/rw/wr_data/be driven, then SHALL go to WAIT.
REQ-026 In WAIT, addr/rw/wr_data/be SHALL be held; on bus_rdy_=0 the FIFO SHALL pop (for a store) or data SHALL be captured (for a load), and the FSM SHALL return to IDLE.
REQ-027 bus_req_ SHALL stay 0 from REQ through WAIT.
REQ-028 A simultaneous enqueue and pop on a full FIFO SHALL be allowed, with no loss and no spurious busy; the FIFO pointers SHALL wrap modulo SB_DEPTH.
REQ-029 The MEM/WB register SHALL capture the pass-through fields, the result and the exception code when stall=0 and flush=0.
REQ-030 When stall=1 the MEM/WB register SHALL hold.
REQ-031 When flush=1 and stall=0, the MEM/WB register SHALL load mem_en=0, mem_gpr_we_=1, mem_exp_code=0 and all others 0.
REQ-032 flush SHALL cancel a pending, not-yet-granted load; a store already in the FIFO SHALL still drain.

Reset
REQ-033 On reset=1 at a clk edge, the FSM SHALL go to IDLE, the FIFO SHALL be emptied and the hold register invalidated.
REQ-034 Reset values SHALL be: bus_req_=1, bus_as_=1, bus_rw=1, bus_be=0, mem_en=0, mem_gpr_we_=1, mem_exp_code=0, all other mem_* =0.
REQ-035 busy SHALL be 0 on the cycle after reset deasserts, and reset mid-transaction SHALL abort the transaction without a pop.

Verification
REQ-036 LB at SPM addr SPM_BASE+3 with spm_rd_data=0x80FF_FF00 -> mem_out=0xFFFF_FF80 the next cycle, busy=0 throughout.
REQ-037 SH to bus addr 0x8000_0002, data 0x1234 -> bus_be=1100 and bus_wr_data=0x1234_1234 in ACCESS, with no busy asserted.
REQ-038 SW to 0x8000_0001 -> mem_exp_code=EXP_MISALIGN and mem_gpr_we_=1, with bus_as_ and spm_as_ never low.
REQ-039 Five back-to-back bus SW with SB_DEPTH=4 and grant withheld -> busy=1 on the 5th; grant released -> all 5 stores appear on the bus in order.
REQ-040 LW from bus with 2 stores queued -> both stores complete before the load's bus_as_; mem_out equals bus_rd_data latched on bus_rdy_=0.
REQ-041 reset asserted in WAIT -> the next cycle shows bus_req_=1, the FIFO empty and busy=0.

Source files
------------

// File: rtl/lsu_stage_if.sv
// System bus port of the load/store stage: request/grant arbitration plus
// address-strobe / ready handshake, all control strobes active-low.
interface lsu_stage_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rdy_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wr_data;
  logic [31:0]       bus_rd_data;
  logic [3:0]        bus_be;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, bus_be,
    input  bus_grnt_, bus_rdy_, bus_rd_data
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, bus_be,
    output bus_grnt_, bus_rdy_, bus_rd_data
  );
endinterface

// File: rtl/lsu_stage.sv
// MEM stage: zero-wait scratchpad access, posted bus stores through a small
// store buffer, blocking bus loads, and the MEM/WB pipeline register.
module lsu_stage #(
  parameter int               ADDR_W       = 32,
  parameter int               SB_DEPTH     = 4,
  parameter logic [ADDR_W-1:0] SPM_BASE    = '0,
  parameter int               SPM_AW       = 14,
  parameter logic [2:0]       EXP_MISALIGN = 3'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  input  logic [31:0]       spm_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [31:0]       spm_wr_data,
  output logic [3:0]        spm_be,
  lsu_stage_if.master       bus,
  input  logic              ex_en,
  input  logic [3:0]        ex_mem_op,
  input  logic [31:0]       ex_mem_wr_data,
  input  logic [31:0]       ex_out,
  input  logic [31:0]       ex_pc,
  input  logic              ex_br_flag,
  input  logic [1:0]        ex_ctrl_op,
  input  logic [4:0]        ex_dst_addr,
  input  logic              ex_gpr_we_,
  input  logic [2:0]        ex_exp_code,
  output logic [31:0]       fwd_data,
  output logic [31:0]       mem_pc,
  output logic              mem_en,
  output logic              mem_br_flag,
  output logic [1:0]        mem_ctrl_op,
  output logic [4:0]        mem_dst_addr,
  output logic              mem_gpr_we_,
  output logic [2:0]        mem_exp_code,
  output logic [31:0]       mem_out
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] SB_FULL = (PTR_W+1)'(SB_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } sb_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACCESS, S_WAIT} state_t;

  // ---- decode ----
  logic [ADDR_W-1:0] addr;
  logic is_load, is_store, is_byte, is_half, is_word;
  logic misalign, access, in_spm, bus_st, bus_ld;
  logic [3:0]  acc_be;
  logic [31:0] st_data;

  assign addr     = ex_out[ADDR_W-1:0];
  assign is_load  = ex_mem_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  assign is_store = ex_mem_op inside {4'd6, 4'd7, 4'd8};
  assign is_byte  = ex_mem_op inside {4'd1, 4'd4, 4'd6};
  assign is_half  = ex_mem_op inside {4'd2, 4'd5, 4'd7};
  assign is_word  = ex_mem_op inside {4'd3, 4'd8};
  assign misalign = ex_en & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
  assign access   = ex_en & (is_load | is_store) & ~misalign;
  assign in_spm   = addr[ADDR_W-1:SPM_AW] == SPM_BASE[ADDR_W-1:SPM_AW];
  assign bus_st   = access & ~in_spm & is_store;
  assign bus_ld   = access & ~in_spm & is_load;

  always_comb begin
    acc_be  = 4'b1111;
    st_data = ex_mem_wr_data;
    if (is_byte) begin
      acc_be  = 4'b0001 << addr[1:0];
      st_data = {4{ex_mem_wr_data[7:0]}};
    end else if (is_half) begin
      acc_be  = 4'b0011 << addr[1:0];
      st_data = {2{ex_mem_wr_data[15:0]}};
    end
  end

  assign spm_addr    = addr;
  assign spm_as_     = ~(access & in_spm);
  assign spm_rw      = ~is_store;
  assign spm_wr_data = st_data;
  assign spm_be      = acc_be;

  // ---- load alignment; bus loads read from the hold register ----
  logic        hold_vld;
  logic [31:0] hold_data, rd_word, ld_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_word = in_spm ? spm_rd_data : hold_data;
    rd_byte = 8'(rd_word >> {addr[1:0], 3'b000});
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (ex_mem_op)
      4'd1:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      4'd2:    ld_data = {{16{rd_half[15]}}, rd_half};
      4'd4:    ld_data = {24'd0, rd_byte};
      4'd5:    ld_data = {16'd0, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  assign fwd_data = (access & is_load) ? ld_data : ex_out;

  // ---- store buffer ----
  sb_entry_t        sb_mem [SB_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   sb_cnt;
  logic             sb_empty, sb_full, push, pop, busy_st, busy_ld;
  state_t           state_q, state_d;
  logic             op_ld_q, ld_drop, start_st, start_ld, ld_pend, done;

  assign sb_empty = sb_cnt == '0;
  assign sb_full  = sb_cnt == SB_FULL;
  assign done     = (state_q == S_WAIT) & ~bus.bus_rdy_;
  assign pop      = done & ~op_ld_q;
  // A pop in the same cycle frees a slot, so a full buffer does not stall then.
  assign busy_st  = bus_st & sb_full & ~pop;
  assign push     = bus_st & ~stall & ~flush & ~busy_st;
  assign busy_ld  = bus_ld & ~hold_vld;
  assign busy     = busy_st | busy_ld;
  assign ld_pend  = bus_ld & ~hold_vld & ~flush;

  always_ff @(posedge clk) begin
    if (push) sb_mem[wr_ptr] <= '{addr: addr, data: st_data, be: acc_be};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sb_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   sb_cnt <= sb_cnt + 1'b1;
        2'b01:   sb_cnt <= sb_cnt - 1'b1;
        default: sb_cnt <= sb_cnt;
      endcase
    end
  end

  // ---- bus FSM ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_st = 1'b0;
    start_ld = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sb_empty) begin
          state_d  = S_REQ;
          start_st = 1'b1;
        end else if (ld_pend) begin
          state_d  = S_REQ;
          start_ld = 1'b1;
        end
      end
      S_REQ: begin
        // An ungranted load is dropped if its instruction is squashed.
        if (op_ld_q && (flush || !bus_ld)) state_d = S_IDLE;
        else if (!bus.bus_grnt_)           state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   if (!bus.bus_rdy_) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  logic [ADDR_W-1:0] txn_addr;
  logic [31:0]       txn_data;
  logic [3:0]        txn_be;
  logic              txn_rw;

  always_ff @(posedge clk) begin
    if (reset) begin
      txn_addr <= '0;
      txn_data <= '0;
      txn_be   <= '0;
      txn_rw   <= 1'b1;
      op_ld_q  <= 1'b0;
      ld_drop  <= 1'b0;
    end else if (start_st) begin
      txn_addr <= sb_mem[rd_ptr].addr;
      txn_data <= sb_mem[rd_ptr].data;
      txn_be   <= sb_mem[rd_ptr].be;
      txn_rw   <= 1'b0;
      op_ld_q  <= 1'b0;
    end else if (start_ld) begin
      txn_addr <= addr;
      txn_data <= '0;
      txn_be   <= acc_be;
      txn_rw   <= 1'b1;
      op_ld_q  <= 1'b1;
      ld_drop  <= 1'b0;
    end else if (flush && op_ld_q && (state_q == S_ACCESS || state_q == S_WAIT)) begin
      ld_drop  <= 1'b1;
    end
  end

  logic txn_on;
  assign txn_on          = (state_q == S_ACCESS) | (state_q == S_WAIT);
  assign bus.bus_req_    = state_q == S_IDLE;
  assign bus.bus_as_     = state_q != S_ACCESS;
  assign bus.bus_addr    = txn_on ? txn_addr : '0;
  assign bus.bus_rw      = txn_on ? txn_rw   : 1'b1;
  assign bus.bus_wr_data = txn_on ? txn_data : '0;
  assign bus.bus_be      = txn_on ? txn_be   : 4'b0000;

  // Granted loads whose instruction was flushed complete on the bus but are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (done && op_ld_q && !ld_drop && !flush) begin
      hold_vld  <= 1'b1;
      hold_data <= bus.bus_rd_data;
    end else if (!stall) begin
      hold_vld  <= 1'b0;
    end
  end

  // ---- MEM/WB register ----
  always_ff @(posedge clk) begin
    if (reset || (flush && !stall)) begin
      mem_pc       <= '0;
      mem_en       <= 1'b0;
      mem_br_flag  <= 1'b0;
      mem_ctrl_op  <= '0;
      mem_dst_addr <= '0;
      mem_gpr_we_  <= 1'b1;
      mem_exp_code <= '0;
      mem_out      <= '0;
    end else if (!stall) begin
      mem_pc       <= ex_pc;
      mem_en       <= ex_en;
      mem_br_flag  <= ex_br_flag;
      mem_ctrl_op  <= ex_ctrl_op;
      mem_dst_addr <= ex_dst_addr;
      mem_gpr_we_  <= misalign ? 1'b1 : ex_gpr_we_;
      mem_exp_code <= misalign ? EXP_MISALIGN : ex_exp_code;
      mem_out      <= misalign ? ex_out : fwd_data;
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: SPM loads/stores, posted bus stores, blocking
// bus loads, misalign, flush and reset-in-transaction behaviour.
module tb_lsu_stage;
  logic        clk, reset, tb_stall, flush, stall, busy;
  logic [31:0] spm_rd_data, spm_wr_data, fwd_data, mem_pc, mem_out;
  logic [31:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [3:0]  spm_be;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data, ex_out, ex_pc;
  logic [1:0]  ex_ctrl_op, mem_ctrl_op;
  logic [4:0]  ex_dst_addr, mem_dst_addr;
  logic [2:0]  ex_exp_code, mem_exp_code;
  logic        mem_en, mem_br_flag, mem_gpr_we_;
  int          nvec, nmiss;

  lsu_stage_if #(.ADDR_W(32)) bif ();

  // The pipeline stalls whenever the stage asks for it.
  assign stall = tb_stall | busy;

  lsu_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_wr_data(spm_wr_data), .spm_be(spm_be),
    .bus(bif.master),
    .ex_en(ex_en), .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_out(ex_out), .ex_pc(ex_pc), .ex_br_flag(ex_br_flag),
    .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
    .ex_exp_code(ex_exp_code), .fwd_data(fwd_data), .mem_pc(mem_pc),
    .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
    .mem_exp_code(mem_exp_code), .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    ex_en = 1'b1; ex_mem_op = op; ex_out = a; ex_mem_wr_data = d;
  endtask

  task automatic idle();
    ex_en = 1'b0; ex_mem_op = 4'd0;
  endtask

  task automatic wait_as(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bif.bus_as_ === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Acts as the bus slave for one transaction; ready is given the cycle after ACCESS.
  task automatic bus_txn(input logic [31:0] rdata, output logic [31:0] a, output logic [31:0] d,
                         output logic [3:0] be, output logic rw, output logic b_rdy, output logic ok);
    wait_as(ok);
    a = bif.bus_addr; d = bif.bus_wr_data; be = bif.bus_be; rw = bif.bus_rw; b_rdy = 1'b0;
    if (ok) begin
      tick();
      bif.bus_rd_data = rdata; bif.bus_rdy_ = 1'b0;
      #1 b_rdy = busy;
      tick();
      bif.bus_rdy_ = 1'b1;
    end
  endtask

  logic [31:0] a, d;
  logic [3:0]  be;
  logic        rw, brdy, ok;
  logic [3:0]  ld_op  [7];
  logic [31:0] ld_adr [7];
  logic [31:0] ld_exp [7];

  initial begin
    nvec = 0; nmiss = 0;
    reset = 1'b1; tb_stall = 1'b0; flush = 1'b0;
    ex_en = 1'b0; ex_mem_op = '0; ex_mem_wr_data = '0; ex_out = '0; ex_pc = '0;
    ex_br_flag = 1'b0; ex_ctrl_op = '0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1; ex_exp_code = '0;
    spm_rd_data = '0;
    bif.bus_rd_data = '0; bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk1("rst_bus_req_", bif.bus_req_, 1'b1);
    chk1("rst_bus_as_", bif.bus_as_, 1'b1);
    chk1("rst_bus_rw", bif.bus_rw, 1'b1);
    chk("rst_bus_be", {28'd0, bif.bus_be}, 32'd0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_gpr_we_", mem_gpr_we_, 1'b1);
    chk("rst_mem_exp_code", {29'd0, mem_exp_code}, 32'd0);
    chk("rst_mem_out", mem_out, 32'd0);
    chk1("rst_busy", busy, 1'b0);

    // SPM LB with sign extension
    ex_pc = 32'h100; ex_dst_addr = 5'd5; ex_gpr_we_ = 1'b0; ex_br_flag = 1'b1; ex_ctrl_op = 2'd2;
    spm_rd_data = 32'h80FF_FF00;
    present(4'd1, 32'h0000_0003, 32'd0);
    #1;
    chk1("spm_lb_as_", spm_as_, 1'b0);
    chk1("spm_lb_busy", busy, 1'b0);
    chk("spm_lb_fwd", fwd_data, 32'hFFFF_FF80);
    tick();
    chk("spm_lb_mem_out", mem_out, 32'hFFFF_FF80);
    chk("spm_lb_mem_pc", mem_pc, 32'h100);
    chk("spm_lb_mem_dst", {27'd0, mem_dst_addr}, 32'd5);
    chk1("spm_lb_mem_en", mem_en, 1'b1);
    chk1("spm_lb_mem_br", mem_br_flag, 1'b1);
    chk1("spm_lb_busy2", busy, 1'b0);

    ld_op[0] = 4'd4; ld_adr[0] = 32'd3; ld_exp[0] = 32'h0000_0080;
    ld_op[1] = 4'd1; ld_adr[1] = 32'd1; ld_exp[1] = 32'hFFFF_FFFF;
    ld_op[2] = 4'd2; ld_adr[2] = 32'd2; ld_exp[2] = 32'hFFFF_80FF;
    ld_op[3] = 4'd5; ld_adr[3] = 32'd2; ld_exp[3] = 32'h0000_80FF;
    ld_op[4] = 4'd2; ld_adr[4] = 32'd0; ld_exp[4] = 32'hFFFF_FF00;
    ld_op[5] = 4'd3; ld_adr[5] = 32'd0; ld_exp[5] = 32'h80FF_FF00;
    ld_op[6] = 4'd9; ld_adr[6] = 32'h1234; ld_exp[6] = 32'h0000_1234;
    for (int i = 0; i < 7; i++) begin
      present(ld_op[i], ld_adr[i], 32'd0);
      #1 chk($sformatf("spm_ld%0d_fwd", i), fwd_data, ld_exp[i]);
      tick();
    end

    // SPM byte store: lane replication and byte enable
    present(4'd6, 32'h0000_0002, 32'h0000_00AB);
    #1;
    chk("spm_sb_be", {28'd0, spm_be}, 32'h4);
    chk("spm_sb_data", spm_wr_data, 32'hABAB_ABAB);
    chk1("spm_sb_rw", spm_rw, 1'b0);
    tick(); idle(); tick();
    chk1("spm_sb_no_bus", bif.bus_req_, 1'b1);

    // Posted bus SH
    bif.bus_grnt_ = 1'b0;
    present(4'd7, 32'h8000_0002, 32'h0000_1234);
    #1 chk1("sh_busy", busy, 1'b0);
    tick(); idle();
    bus_txn(32'd0, a, d, be, rw, brdy, ok);
    chk1("sh_txn_ok", ok, 1'b1);
    chk("sh_addr", a, 32'h8000_0002);
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_data", d, 32'h1234_1234);
    chk1("sh_rw", rw, 1'b0);

    // Misaligned SW
    present(4'd8, 32'h8000_0001, 32'h0000_FFFF);
    #1;
    chk1("mis_spm_as_", spm_as_, 1'b1);
    chk1("mis_busy", busy, 1'b0);
    tick(); idle();
    chk("mis_exp", {29'd0, mem_exp_code}, 32'd4);
    chk1("mis_gpr_we_", mem_gpr_we_, 1'b1);
    chk("mis_out", mem_out, 32'h8000_0001);
    tick(); tick(); tick();
    chk1("mis_no_req", bif.bus_req_, 1'b1);
    chk1("mis_no_as", bif.bus_as_, 1'b1);

    // Five SW with grant withheld: the fifth finds the buffer full
    bif.bus_grnt_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      present(4'd8, 32'h8000_0010 + 32'(4 * i), 32'hA0A0_0000 + 32'(i));
      #1 chk1($sformatf("sb%0d_busy", i), busy, i == 4);
      if (i < 4) tick();
    end
    tick(); tick();
    chk1("sb_full_busy_held", busy, 1'b1);
    bif.bus_grnt_ = 1'b0;
    bus_txn(32'd0, a, d, be, rw, brdy, ok);
    idle();
    chk1("sb0_ok", ok, 1'b1);
    chk("sb0_addr", a, 32'h8000_0010);
    chk("sb0_data", d, 32'hA0A0_0000);
    chk1("sb0_busy_at_pop", brdy, 1'b0);
    for (int i = 1; i < 5; i++) begin
      bus_txn(32'd0, a, d, be, rw, brdy, ok);
      chk1($sformatf("sb%0d_ok", i), ok, 1'b1);
      chk($sformatf("sb%0d_addr", i), a, 32'h8000_0010 + 32'(4 * i));
      chk($sformatf("sb%0d_data", i), d, 32'hA0A0_0000 + 32'(i));
    end
    tick(); tick(); tick();
    chk1("sb_drained", bif.bus_req_, 1'b1);

    // Bus LW behind two queued stores
    bif.bus_grnt_ = 1'b1;
    present(4'd8, 32'h8000_0100, 32'h0000_0011); tick();
    present(4'd8, 32'h8000_0104, 32'h0000_0022); tick();
    ex_dst_addr = 5'd7; ex_gpr_we_ = 1'b0;
    present(4'd3, 32'h8000_0200, 32'd0);
    #1 chk1("lw_busy", busy, 1'b1);
    bif.bus_grnt_ = 1'b0;
    bus_txn(32'd0, a, d, be, rw, brdy, ok);
    chk1("lw_st0_rw", rw, 1'b0);
    chk("lw_st0_addr", a, 32'h8000_0100);
    chk("lw_st0_data", d, 32'h0000_0011);
    bus_txn(32'd0, a, d, be, rw, brdy, ok);
    chk1("lw_st1_rw", rw, 1'b0);
    chk("lw_st1_addr", a, 32'h8000_0104);
    bus_txn(32'hDEAD_BEEF, a, d, be, rw, brdy, ok);
    chk1("lw_ok", ok, 1'b1);
    chk1("lw_rw", rw, 1'b1);
    chk("lw_addr", a, 32'h8000_0200);
    chk("lw_be", {28'd0, be}, 32'hF);
    chk1("lw_busy_at_rdy", brdy, 1'b1);
    chk1("lw_busy_after", busy, 1'b0);
    chk("lw_fwd", fwd_data, 32'hDEAD_BEEF);
    tick(); idle();
    chk("lw_mem_out", mem_out, 32'hDEAD_BEEF);
    chk("lw_mem_dst", {27'd0, mem_dst_addr}, 32'd7);

    // Flush and stall on the MEM/WB register
    ex_pc = 32'h200; ex_gpr_we_ = 1'b0;
    present(4'd0, 32'h0000_0055, 32'd0);
    flush = 1'b1;
    tick();
    chk1("fl_mem_en", mem_en, 1'b0);
    chk1("fl_gpr_we_", mem_gpr_we_, 1'b1);
    chk("fl_mem_out", mem_out, 32'd0);
    chk("fl_mem_pc", mem_pc, 32'd0);
    flush = 1'b0;
    tick();
    chk("adv_mem_out", mem_out, 32'h55);
    chk1("adv_mem_en", mem_en, 1'b1);
    chk1("adv_gpr_we_", mem_gpr_we_, 1'b0);
    tb_stall = 1'b1; ex_out = 32'h66;
    tick();
    chk("stall_hold", mem_out, 32'h55);
    tb_stall = 1'b0; idle();

    // Flush cancels an ungranted bus load
    bif.bus_grnt_ = 1'b1;
    present(4'd3, 32'h8000_0300, 32'd0);
    tick();
    chk1("fl_ld_req", bif.bus_req_, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0; idle();
    bif.bus_grnt_ = 1'b0;
    tick(); tick(); tick();
    chk1("fl_ld_cancel", bif.bus_req_, 1'b1);

    // Reset while a store waits for ready
    bif.bus_grnt_ = 1'b1;
    present(4'd8, 32'h8000_0500, 32'd1); tick();
    present(4'd8, 32'h8000_0504, 32'd2); tick();
    idle();
    bif.bus_grnt_ = 1'b0;
    wait_as(ok);
    chk1("rw_access_ok", ok, 1'b1);
    tick();
    chk1("rw_in_wait_req", bif.bus_req_, 1'b0);
    reset = 1'b1;
    tick();
    chk1("rw_req_", bif.bus_req_, 1'b1);
    chk1("rw_busy", busy, 1'b0);
    reset = 1'b0;
    present(4'd3, 32'h8000_0600, 32'd0);
    bus_txn(32'h0BAD_F00D, a, d, be, rw, brdy, ok);
    chk1("rw_first_is_load", rw, 1'b1);
    chk("rw_ld_addr", a, 32'h8000_0600);
    chk("rw_ld_fwd", fwd_data, 32'h0BAD_F00D);
    tick(); idle();
    chk("rw_ld_out", mem_out, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
